// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD scan controller: state encoding,
// digit width constants and a BCD validity helper.
package bcd_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // A 4-bit code is displayable only when it is a decimal digit.
  function automatic logic is_valid_bcd(input logic [BCD_W-1:0] code);
    return code <= BCD_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_lzb_mask.sv
// Leading-zero blank mask. Bit k is set when blanking is enabled, k is not
// the least significant digit, and every digit from the top down to k is 0.
// Digit 0 is never blanked, so its code is not needed here: only the upper
// digits are passed in (upper digit j sits at bits [4(j-1)+3 : 4(j-1)]).
module bcd_lzb_mask
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [(NUM_DIGITS-1)*BCD_W-1:0] upper,
  input  logic                            lzb_en,
  output logic [NUM_DIGITS-1:0]           blank
);

  // zero_above[k] = digits NUM_DIGITS-1 .. k are all zero
  logic [NUM_DIGITS:1] zero_above;

  assign zero_above[NUM_DIGITS] = 1'b1;
  assign blank[0]               = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_digit
      assign zero_above[gi] = (upper[(gi-1)*BCD_W +: BCD_W] == '0) && zero_above[gi+1];
      assign blank[gi]      = lzb_en && zero_above[gi];
    end
  endgenerate

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed scan controller sharing one BCD-to-decimal decoder among
// NUM_DIGITS digits, with a one-cycle blanking gap between digits, a double
// buffered display value, invalid-code suppression and leading-zero blanking.
// Outputs are registered from the next-state values, so they line up with
// the state register.
module bcd_scan_ctrl
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  input  logic                        load,
  input  logic                        lzb_en,
  input  logic                        err_clr,
  output logic [BCD_W-1:0]            dec_code,
  output logic                        dec_valid,
  output logic [NUM_DIGITS-1:0]       dig_sel,
  output logic                        frame_done,
  output logic                        err
);

  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t                   state_reg, state_next;
  logic [IDX_W-1:0]              idx_reg, idx_next;
  logic [CNT_W-1:0]              cnt_reg, cnt_next;
  logic [BCD_W*NUM_DIGITS-1:0]   shadow_reg, shadow_next;
  logic [BCD_W*NUM_DIGITS-1:0]   active_reg, active_next;
  logic                          pending_reg, pending_next;
  logic                          copy_req;

  logic [BCD_W-1:0]              dec_code_reg, dec_code_next;
  logic                          dec_valid_reg, dec_valid_next;
  logic [NUM_DIGITS-1:0]         dig_sel_reg, dig_sel_next;
  logic                          frame_done_reg, frame_done_next;
  logic                          err_reg, err_next;
  logic                          err_set;

  logic [BCD_W-1:0]              digit_arr [NUM_DIGITS];
  logic [BCD_W-1:0]              cur_code;
  logic [NUM_DIGITS-1:0]         blank_mask;

  // Split the next active value into addressable digits.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_split
      assign digit_arr[gi] = active_next[gi*BCD_W +: BCD_W];
    end
  endgenerate

  bcd_lzb_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lzb_mask (
    .upper  (active_next[BCD_W*NUM_DIGITS-1:BCD_W]),
    .lzb_en (lzb_en),
    .blank  (blank_mask)
  );

  // Scan FSM: next state, digit index, dwell counter and frame-boundary copy.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    copy_req   = 1'b0;
    if (!en) begin
      state_next = IDLE;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = SHOW;
          idx_next   = '0;
          cnt_next   = DWELL_LAST;
          copy_req   = 1'b1;
        end
        SHOW: begin
          if (cnt_reg == '0) begin
            state_next = GAP;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        GAP: begin
          state_next = SHOW;
          cnt_next   = DWELL_LAST;
          if (idx_reg == IDX_LAST) begin
            idx_next = '0;
            copy_req = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Double buffer: a load always lands in shadow and keeps pending set,
  // even when it coincides with the copy into active.
  always_comb begin
    shadow_next  = load ? bcd_in : shadow_reg;
    pending_next = load | (pending_reg & ~copy_req);
    active_next  = (copy_req && pending_reg) ? shadow_reg : active_reg;
  end

  // Output decode from the next state, plus sticky error (set wins over clear).
  always_comb begin
    dec_code_next   = dec_code_reg;
    dec_valid_next  = 1'b0;
    dig_sel_next    = '0;
    frame_done_next = 1'b0;
    err_set         = 1'b0;
    cur_code        = digit_arr[idx_next];
    case (state_next)
      SHOW: begin
        dig_sel_next   = NUM_DIGITS'(1) << idx_next;
        dec_code_next  = cur_code;
        dec_valid_next = is_valid_bcd(cur_code) && !blank_mask[idx_next];
        err_set        = !is_valid_bcd(cur_code);
      end
      GAP: begin
        frame_done_next = (idx_next == IDX_LAST);
      end
      default: begin
        dec_code_next = '0;
      end
    endcase
    err_next = err_set | (err_reg & ~err_clr);
  end

  // State, buffer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      shadow_reg     <= '0;
      active_reg     <= '0;
      pending_reg    <= 1'b0;
      dec_code_reg   <= '0;
      dec_valid_reg  <= 1'b0;
      dig_sel_reg    <= '0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      shadow_reg     <= shadow_next;
      active_reg     <= active_next;
      pending_reg    <= pending_next;
      dec_code_reg   <= dec_code_next;
      dec_valid_reg  <= dec_valid_next;
      dig_sel_reg    <= dig_sel_next;
      frame_done_reg <= frame_done_next;
      err_reg        <= err_next;
    end
  end

  assign dec_code   = dec_code_reg;
  assign dec_valid  = dec_valid_reg;
  assign dig_sel    = dig_sel_reg;
  assign frame_done = frame_done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Testbench for bcd_scan_ctrl: directed scenarios followed by random
// stimulus, all checked every cycle against a timeline-based reference model.
module tb_bcd_scan_ctrl;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int FRAME = N * (D + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [4*N-1:0] bcd_in;
  logic           load;
  logic           lzb_en;
  logic           err_clr;
  logic [3:0]     dec_code;
  logic           dec_valid;
  logic [N-1:0]   dig_sel;
  logic           frame_done;
  logic           err;

  always #5 clk = ~clk;

  bcd_scan_ctrl #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bcd_in     (bcd_in),
    .load       (load),
    .lzb_en     (lzb_en),
    .err_clr    (err_clr),
    .dec_code   (dec_code),
    .dec_valid  (dec_valid),
    .dig_sel    (dig_sel),
    .frame_done (frame_done),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position on the display timeline since en rose.
  bit             m_run;
  int             m_phase;
  logic [4*N-1:0] m_shadow;
  logic [4*N-1:0] m_active;
  bit             m_pend;
  bit             m_err;
  logic [3:0]     e_code;
  bit             e_valid;
  logic [N-1:0]   e_sel;
  bit             e_fd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_digit();
    return (m_phase / (D + 1)) % N;
  endfunction

  function automatic int m_pos();
    return m_phase % (D + 1);
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_clock();
    bit         copy;
    bit         gap;
    bit         lead;
    bit         inv;
    int         digit;
    logic [3:0] code;
    copy = 0; inv = 0;
    e_code = 4'd0; e_valid = 0; e_sel = '0; e_fd = 0;
    if (rst) begin
      m_run = 0; m_phase = 0; m_shadow = '0; m_active = '0; m_pend = 0; m_err = 0;
      return;
    end
    if (!en) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1; m_phase = 0; copy = 1;
    end else begin
      m_phase++;
      if (m_phase % FRAME == 0) copy = 1;
    end
    if (copy && m_pend) begin
      m_active = m_shadow;
      m_pend   = 0;
    end
    if (load) begin
      m_shadow = bcd_in;
      m_pend   = 1;
    end
    if (m_run) begin
      digit  = m_digit();
      gap    = (m_pos() == D);
      code   = 4'((m_active >> (4 * digit)) & 16'hF);
      e_code = code;
      if (gap) begin
        e_fd = (digit == N - 1);
      end else begin
        e_sel   = N'(1) << digit;
        lead    = lzb_en && (digit != 0) && ((m_active >> (4 * digit)) == 0);
        inv     = (code > 4'd9);
        e_valid = !inv && !lead;
      end
    end
    m_err = inv | (m_err & !err_clr);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_eq("dig_sel", 32'(dig_sel), 32'(e_sel));
    check_eq("dec_code", 32'(dec_code), 32'(e_code));
    check_eq("dec_valid", 32'(dec_valid), 32'(e_valid));
    check_eq("frame_done", 32'(frame_done), 32'(e_fd));
    check_eq("err", 32'(err), 32'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [4*N-1:0] v);
    bcd_in = v;
    load   = 1'b1;
    $display("load bcd_in=%h t=%0t", v, $time);
    step();
    load   = 1'b0;
  endtask

  // Step until the displayed digit/position matches, bounded by two frames.
  task automatic wait_pos(input int digit, input int pos);
    int n;
    n = 0;
    while (!(m_run && m_digit() == digit && m_pos() == pos) && n < 2 * FRAME) begin
      step();
      n++;
    end
    check_eq("wait_bound", 32'(n < 2 * FRAME), 32'd1);
  endtask

  function automatic logic [4*N-1:0] rand_bcd();
    logic [4*N-1:0] v;
    int             r;
    v = '0;
    for (int k = 0; k < N; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       v[4*k +: 4] = 4'd0;
      else if (r == 9) v[4*k +: 4] = 4'($urandom_range(10, 15));
      else             v[4*k +: 4] = 4'($urandom_range(1, 9));
    end
    if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, N - 1));
    return v;
  endfunction

  int fd_count;
  int sel0_count;

  initial begin
    rst = 1'b1; en = 1'b0; bcd_in = '0; load = 1'b0; lzb_en = 1'b0; err_clr = 1'b0;
    run(2);
    check_eq("rst_sel", 32'(dig_sel), 32'd0);
    check_eq("rst_valid", 32'(dec_valid), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Scenario 1: basic scan of 0x1234
    do_load(16'h1234);
    en = 1'b1;
    step();
    check_eq("s1_first_sel", 32'(dig_sel), 32'h1);
    check_eq("s1_first_code", 32'(dec_code), 32'h4);
    fd_count = 0; sel0_count = 0;
    for (int i = 1; i < 2 * FRAME; i++) begin
      step();
      if (frame_done) fd_count++;
      if (i < FRAME && dig_sel == 4'b0001) sel0_count++;
    end
    check_eq("s1_frame_done_count", 32'(fd_count), 32'd2);
    check_eq("s1_dig0_dwell", 32'(sel0_count + 1), 32'(D));

    // Scenario 2: leading-zero blanking on 0x0050
    lzb_en = 1'b1;
    do_load(16'h0050);
    run(2 * FRAME);
    lzb_en = 1'b0;
    run(FRAME);

    // Scenario 3: invalid code and sticky error
    do_load(16'h12A4);
    run(FRAME + 5);
    wait_pos(1, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check_eq("s3_clr_during_bad", 32'(err), 32'd1);
    wait_pos(3, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check_eq("s3_clr_other_digit", 32'(err), 32'd0);

    // Scenario 4: two loads mid-frame, newest wins at the next boundary
    wait_pos(1, 0);
    do_load(16'h1111);
    step();
    do_load(16'h9999);
    run(2 * FRAME + 5);

    // Scenario 5: drop en during digit 2, then restart at digit 0
    wait_pos(2, 1);
    en = 1'b0; step();
    check_eq("s5_idle_sel", 32'(dig_sel), 32'd0);
    check_eq("s5_idle_code", 32'(dec_code), 32'd0);
    run(3);
    en = 1'b1;
    for (int i = 0; i < D; i++) begin
      step();
      check_eq("s5_restart_sel", 32'(dig_sel), 32'h1);
    end
    step();
    check_eq("s5_gap_sel", 32'(dig_sel), 32'd0);

    // Scenario 6: reset mid-show with a pending load
    wait_pos(1, 1);
    do_load(16'h5678);
    rst = 1'b1; step();
    check_eq("s6_rst_sel", 32'(dig_sel), 32'd0);
    check_eq("s6_rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    step();
    check_eq("s6_code0", 32'(dec_code), 32'd0);
    check_eq("s6_valid0", 32'(dec_valid), 32'd1);
    check_eq("s6_err", 32'(err), 32'd0);
    run(FRAME + 3);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 599) == 0);
      if (en) en = ($urandom_range(0, 149) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) lzb_en = ~lzb_en;
      err_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 24) == 0) begin
        bcd_in = rand_bcd();
        load   = 1'b1;
        $display("load bcd_in=%h t=%0t", bcd_in, $time);
      end else begin
        load = 1'b0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
Time-multiplexing controller that shares one BCD-to-decimal decoder among NUM_DIGITS packed BCD digits. It steps through the digits, drives the shared decoder's 4-bit code inputs and a one-hot digit enable, and inserts a one-cycle blanking gap between digits. It also double-buffers the display value, suppresses invalid codes (10–15) and blanks leading zeros. It sits between the counter/arithmetic datapath that produces BCD values and the decoder/display stage.

Parameters:
NUM_DIGITS, 4, number of BCD digits scanned (2..8)
DWELL_CYCLES, 1000, clock cycles each digit is shown (>=2)
CNT_W, $clog2(DWELL_CYCLES), dwell counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
en  in  1  scan enable; low forces IDLE
bcd_in  in  4*NUM_DIGITS  packed digits, digit k at bits [4k+3:4k], digit 0 = least significant
load  in  1  capture bcd_in into shadow register this cycle
lzb_en  in  1  leading-zero blanking enable
err_clr  in  1  clears sticky err
dec_code  out  4  code to shared decoder (A3..A0 = dec_code[3:0])
dec_valid  out  1  decoder output is to be displayed this cycle
dig_sel  out  NUM_DIGITS  one-hot active digit; all-zero when blanked
frame_done  out  1  one-cycle pulse after the last digit's dwell
err  out  1  sticky: an invalid BCD code (>9) was scanned

Behaviour:
- Reset is synchronous and active-high on clk. Reset forces state=IDLE, digit index=0, dwell counter=0, shadow=0, active=0, pending=0. All outputs are 0.
- All outputs are registered; each reflects state one cycle after the transition that causes it.
- Double buffer: load=1 writes bcd_in to shadow and sets pending. At each frame boundary (the GAP after the last digit), or on the IDLE->SHOW entry, if pending=1 then active<=shadow and pending<=0. load arriving in the same cycle as the copy wins: the new value goes to shadow and pending stays 1. The active register never changes mid-frame.
- FSM states:
  IDLE: outputs 0. When en=1, go to SHOW with idx=0 and counter=DWELL_CYCLES-1.
  SHOW: dig_sel=1<<idx, dec_code=active[idx]. Counter decrements every cycle; at 0, go to GAP.
  GAP: exactly 1 cycle; dig_sel=0, dec_valid=0, dec_code holds. Then idx<=idx+1 and return to SHOW. If idx=NUM_DIGITS-1, idx wraps to 0, frame_done pulses and the buffer copy occurs.
- en=0 in any state: next state is IDLE and idx resets. The rising edge of en restarts at digit 0 with a full dwell.
- dec_valid in SHOW is 1 unless one of these holds:
  (a) active[idx] > 9. dec_valid=0 and err is set (sticky).
  (b) lzb_en=1, idx != 0, and every digit from NUM_DIGITS-1 down to idx is 0. dec_valid=0 and dig_sel is still asserted.
- Digit 0 is never leading-zero blanked, so the value 0000 shows a single "0".
- err: set on the cycle any invalid code is presented in SHOW. Cleared by err_clr unless it is set in the same cycle (set wins). Cleared by rst.
- Digit period = DWELL_CYCLES+1 cycles. Frame period = NUM_DIGITS*(DWELL_CYCLES+1) cycles.

Decomposition:
- Shared package bcd_pkg holds:
  - the state encoding (IDLE, SHOW, GAP)
  - BCD_W=4
  - BCD_MAX=9
  - a function is_valid_bcd(code)
- One sub-module: bcd_lzb_mask. It is combinational and computes a NUM_DIGITS-bit blank mask from the active register and lzb_en, so it can be verified stand-alone.
- Dwell counter and FSM stay in the top module.

Test Plan:
1. Defaults with DWELL_CYCLES=4. rst, load 0x1234, en=1. Expect dig_sel sequence 0001,0000,0010,0000,0100,0000,1000,0000. Expect dec_code 4,3,2,1, each held 4 cycles, and frame_done once every 20 cycles.
2. Load 0x0050 with lzb_en=1. Expect dec_valid=0 for digits 3 and 2, and 1 for digits 1 (code 5) and 0 (code 0). With lzb_en=0, all four digits are valid.
3. Load 0x12A4. Expect dec_valid=0 on digit 1 and err=1 thereafter. err_clr pulsed while digit 1 is shown keeps err=1; err_clr pulsed on another digit clears it.
4. Load 0x1111 mid-frame, then 0x9999 two cycles later. The current frame keeps its old value; the next frame shows 9999; frame_done aligns with the update.
5. Drop en during digit 2's dwell. Next cycle is IDLE with outputs 0. Re-assert en: digit 0 starts with a full 4-cycle dwell.
6. Assert rst mid-SHOW with pending=1. Next cycle all outputs are 0; after en, 0000 is displayed (shadow was cleared) and err=0.
